// File: rtl/sequential_q2_pkg.sv
// ---------------------------------------------------------------------------
// sequential_q2_pkg
// Shared constants and helpers for the sequential_q2 delay line.
//   MIN_DELAY   : smallest legal number of register stages per tap
//   delay_legal : returns 1 when a tap depth is a legal configuration
// ---------------------------------------------------------------------------
package sequential_q2_pkg;

    localparam int MIN_DELAY = 1;

    function automatic bit delay_legal(input int depth);
        return (depth >= MIN_DELAY);
    endfunction

endpackage : sequential_q2_pkg

// File: rtl/sequential_q2_delay_stage.sv
// ---------------------------------------------------------------------------
// delay_stage
// Parameterised-depth single-bit shift register with asynchronous,
// active-low reset. Every stage shifts on every rising clock edge.
// Ports:
//   clk   : clock, rising edge active
//   rstn  : asynchronous active-low reset, loads RESET_VAL into all stages
//   d_i   : serial data in, captured into stage 0
//   q_o   : last stage (d_i delayed by DEPTH edges), straight from a flop
// ---------------------------------------------------------------------------
module delay_stage #(
    parameter int   DEPTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    // Next-state wiring: stage 0 takes the input, every later stage takes
    // its predecessor, so the whole register shifts as one on each edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign stage_d[gi] = d_i;
            end else begin : g_body
                assign stage_d[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule : delay_stage

// File: rtl/sequential_q2.sv
// ---------------------------------------------------------------------------
// sequential_q2
// Two-tap registered delay line for a single-bit control signal.
// Ports:
//   clk  : single system clock, rising edge active
//   rstn : asynchronous active-low reset (release must be synchronised
//          by the caller)
//   a    : data input, sampled on every rising edge
//   b    : a delayed B_DELAY edges, registered
//   c    : b delayed a further C_DELAY edges, registered
// ---------------------------------------------------------------------------
module sequential_q2
    import sequential_q2_pkg::*;
#(
    parameter int   B_DELAY   = 1,
    parameter int   C_DELAY   = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic a,
    output logic b,
    output logic c
);

    // A zero-depth tap would make an output combinational (or undefined),
    // so such configurations are refused at elaboration.
    generate
        if (!delay_legal(B_DELAY)) begin : g_bad_b_delay
            $fatal(1, "sequential_q2: B_DELAY must be >= 1");
        end
        if (!delay_legal(C_DELAY)) begin : g_bad_c_delay
            $fatal(1, "sequential_q2: C_DELAY must be >= 1");
        end
    endgenerate

    logic b_tap;
    logic c_tap;

    delay_stage #(
        .DEPTH     (B_DELAY),
        .RESET_VAL (RESET_VAL)
    ) u_b_stage (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (a),
        .q_o  (b_tap)
    );

    // The c tap is fed from the b flop output, so c is always a pure
    // delayed copy of b and shares its reset behaviour.
    delay_stage #(
        .DEPTH     (C_DELAY),
        .RESET_VAL (RESET_VAL)
    ) u_c_stage (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (b_tap),
        .q_o  (c_tap)
    );

    assign b = b_tap;
    assign c = c_tap;

endmodule : sequential_q2

// File: tb/tb_sequential_q2.sv
// ---------------------------------------------------------------------------
// tb_sequential_q2
// Scoreboard bench for sequential_q2: a default instance (1/1) and a
// B_DELAY=3 / C_DELAY=2 instance share clock and reset; each has its own
// data input. Stimulus pushes hand-computed expectations into a queue and
// a monitor process pops and compares them against the live outputs.
// ---------------------------------------------------------------------------
module tb_sequential_q2;

    logic clk;
    logic rstn;
    logic a;
    logic b;
    logic c;
    logic a2;
    logic b2;
    logic c2;

    sequential_q2 dut (
        .clk  (clk),
        .rstn (rstn),
        .a    (a),
        .b    (b),
        .c    (c)
    );

    sequential_q2 #(
        .B_DELAY   (3),
        .C_DELAY   (2),
        .RESET_VAL (1'b0)
    ) dut32 (
        .clk  (clk),
        .rstn (rstn),
        .a    (a2),
        .b    (b2),
        .c    (c2)
    );

    // Rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  b;
        logic  c;
        logic  b2;
        logic  c2;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic chk_req = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Queue an expectation and wake the monitor at the current time.
    task automatic expect_now(input string name, input logic eb, input logic ec,
                              input logic eb2, input logic ec2);
        exp_t e;
        e.name = name;
        e.b    = eb;
        e.c    = ec;
        e.b2   = eb2;
        e.c2   = ec2;
        exp_q.push_back(e);
        chk_req = ~chk_req;
    endtask

    // Advance to 2 ns after the next rising edge (stable sampling point).
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: drains every queued expectation and compares with the DUTs.
    always @(chk_req) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            n_checks++;
            if ({b, c, b2, c2} !== {cur.b, cur.c, cur.b2, cur.c2}) begin
                n_errors++;
                $display("FAIL %s @%0t: got b=%b c=%b b2=%b c2=%b, expected b=%b c=%b b2=%b c2=%b",
                         cur.name, $time, b, c, b2, c2, cur.b, cur.c, cur.b2, cur.c2);
            end else begin
                $display("ok   %s @%0t: b=%b c=%b b2=%b c2=%b",
                         cur.name, $time, b, c, b2, c2);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        a    = 1'b0;
        a2   = 1'b0;

        // Reset held with input toggling: everything stays at 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a  = ~a;
            a2 = ~a2;
            tick();
            expect_now("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Release between edges, a low for the first capture.
        @(negedge clk);
        rstn = 1'b1;
        a    = 1'b0;
        a2   = 1'b0;
        tick();
        expect_now("release_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single one-cycle pulse.
        @(negedge clk);
        a = 1'b1;
        tick();
        expect_now("pulse_b_rise", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 1'b0;
        tick();
        expect_now("pulse_c_rise", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_now("pulse_done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Sub-cycle glitch that does not span a rising edge.
        #1 a = 1'b1;
        #3 a = 1'b0;
        tick();
        expect_now("glitch_b", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_now("glitch_c", 1'b0, 1'b0, 1'b0, 1'b0);

        // Alternating input 1,0,1,0.
        @(negedge clk);
        a = 1'b1;
        tick();
        expect_now("alt_1", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 1'b0;
        tick();
        expect_now("alt_2", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        a = 1'b1;
        tick();
        expect_now("alt_3", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 1'b0;
        tick();
        expect_now("alt_4", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_now("alt_5", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_now("alt_6", 1'b0, 1'b0, 1'b0, 1'b0);

        // Fill b and c with 1, then pulse reset off-edge for 3 ns.
        @(negedge clk);
        a = 1'b1;
        tick();
        expect_now("fill_b", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_now("fill_bc", 1'b1, 1'b1, 1'b0, 1'b0);
        #1 rstn = 1'b0;
        #1 expect_now("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rstn = 1'b1;
        #1 expect_now("reset_released", 1'b0, 1'b0, 1'b0, 1'b0);
        // a held at 1: pipeline refills from scratch.
        tick();
        expect_now("refill_1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_now("refill_2", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        a = 1'b0;
        tick();
        expect_now("drain_1", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_now("drain_2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Deeper instance: one-cycle pulse on a2, captured at edge E1.
        @(negedge clk);
        a2 = 1'b1;
        tick();
        expect_now("sweep_e1", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a2 = 1'b0;
        tick();
        expect_now("sweep_e2", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_now("sweep_e3_b", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_now("sweep_e4", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_now("sweep_e5_c", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_now("sweep_e6", 1'b0, 1'b0, 1'b0, 1'b0);

        #1;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sequential_q2
